// File: rtl/mult_div_unit.sv
// ============================================================================
// Module   : mult_div_unit
// Brief    : Iterative multiply/divide unit with architectural HI/LO registers
// Revision : 1.0
// ============================================================================
`default_nettype none

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    input  logic             md_hi_we,
    input  logic             md_lo_we,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] md_hi,
    output logic [WIDTH-1:0] md_lo,
    output logic             md_div_by_zero
);

    localparam int         c_CNT_W = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FIX   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_opb;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    logic               w_signed;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic               w_neg;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_signed = ~md_op[0];
    assign w_sa     = w_signed & md_a[WIDTH-1];
    assign w_sb     = w_signed & md_b[WIDTH-1];
    assign w_a_mag  = w_sa ? (~md_a + 1'b1) : md_a;
    assign w_b_mag  = w_sb ? (~md_b + 1'b1) : md_b;

    // Accumulator layout is shared: upper half is the partial product or the
    // remainder, lower half the multiplier or the dividend/quotient.
    assign w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_opb});
    assign w_diff  = w_shift - {1'b0, r_opb};

    assign w_neg  = r_sign_a ^ r_sign_b;
    assign w_prod = w_neg ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = w_neg ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem  = r_sign_a ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_cnt    <= '0;
            r_opb    <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (md_start) begin
                        r_op     <= md_op;
                        r_sign_a <= w_sa;
                        r_sign_b <= w_sb;
                        r_cnt    <= '0;
                        r_opb    <= w_b_mag;
                        r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                        r_dbz    <= md_op[1] && (md_b == '0);
                        r_state  <= S_CALC;
                    end else begin
                        if (md_hi_we) r_hi <= md_a;
                        if (md_lo_we) r_lo <= md_a;
                    end
                end
                S_CALC: begin
                    if (!r_op[1]) begin
                        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    end else if (w_ge) begin
                        r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                    end else begin
                        r_acc <= {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_W'(WIDTH-1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (!r_op[1]) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else begin
                        // Divide by zero keeps HI = dividend via the remainder path.
                        r_hi <= w_rem;
                        r_lo <= r_dbz ? {WIDTH{1'b1}} : w_quo;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign md_busy        = (r_state != S_IDLE);
    assign md_done        = r_done;
    assign md_hi          = r_hi;
    assign md_lo          = r_lo;
    assign md_div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module   : tb_mult_div_unit
// Brief    : Directed table-driven bench for mult_div_unit
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        md_start;
    logic [1:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_hi_we;
    logic        md_lo_we;
    logic        md_busy;
    logic        md_done;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .md_start       (md_start),
        .md_op          (md_op),
        .md_a           (md_a),
        .md_b           (md_b),
        .md_hi_we       (md_hi_we),
        .md_lo_we       (md_lo_we),
        .md_busy        (md_busy),
        .md_done        (md_done),
        .md_hi          (md_hi),
        .md_lo          (md_lo),
        .md_div_by_zero (md_div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        logic        we;
    } vec_t;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives the start there and follows the op to md_done.
    task automatic run_op(input vec_t v, input string name);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int n;
        int guard;
        old_hi   = md_hi;
        old_lo   = md_lo;
        md_start = 1'b1;
        md_op    = v.op;
        md_a     = v.a;
        md_b     = v.b;
        md_hi_we = v.we;
        md_lo_we = v.we;
        @(negedge clk);
        md_start = 1'b0;
        md_hi_we = 1'b0;
        md_lo_we = 1'b0;
        md_a     = $urandom;
        md_b     = $urandom;
        check({name, " dz_at_start"}, {31'd0, md_div_by_zero}, {31'd0, v.dz});
        n = 0;
        guard = 0;
        while (!md_done && guard < 40) begin
            if (md_busy) n++;
            if (n == 20) begin
                md_hi_we = 1'b1;
                md_start = 1'b1;
            end else begin
                md_hi_we = 1'b0;
                md_start = 1'b0;
            end
            if (n == 25) begin
                check({name, " hold_hi"}, md_hi, old_hi);
                check({name, " hold_lo"}, md_lo, old_lo);
            end
            guard++;
            @(negedge clk);
        end
        md_hi_we = 1'b0;
        md_start = 1'b0;
        check({name, " done"},        {31'd0, md_done}, 32'd1);
        check({name, " busy_cycles"}, n, 32'd33);
        check({name, " busy_at_done"}, {31'd0, md_busy}, 32'd0);
        check({name, " hi"}, md_hi, v.hi);
        check({name, " lo"}, md_lo, v.lo);
        check({name, " dz"}, {31'd0, md_div_by_zero}, {31'd0, v.dz});
    endtask

    vec_t vecs[14];
    vec_t v_tmp;

    initial begin
        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0};
        vecs[3]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[4]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
        vecs[6]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0};
        vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0};
        vecs[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 1'b0};
        vecs[9]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 1'b0};
        vecs[10] = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[11] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
        vecs[12] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0, 1'b0};
        vecs[13] = '{OP_MULTU, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 1'b1};

        rst = 1'b1; md_start = 1'b0; md_op = 2'b00; md_a = '0; md_b = '0;
        md_hi_we = 1'b0; md_lo_we = 1'b0;
        repeat (2) @(negedge clk);
        check("rst busy", {31'd0, md_busy}, 32'd0);
        check("rst done", {31'd0, md_done}, 32'd0);
        check("rst hi", md_hi, 32'd0);
        check("rst lo", md_lo, 32'd0);
        check("rst dz", {31'd0, md_div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Consecutive table entries start in each other's done cycle.
        for (int i = 0; i < 14; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        @(negedge clk);
        md_a = 32'h1234; md_hi_we = 1'b1;
        @(negedge clk);
        md_hi_we = 1'b0;
        check("mthi hi", md_hi, 32'h1234);
        check("mthi lo", md_lo, 32'd15);
        md_a = 32'h5678; md_lo_we = 1'b1;
        @(negedge clk);
        md_lo_we = 1'b0;
        check("mtlo hi", md_hi, 32'h1234);
        check("mtlo lo", md_lo, 32'h5678);
        md_a = 32'hAAAA; md_hi_we = 1'b1; md_lo_we = 1'b1;
        @(negedge clk);
        md_hi_we = 1'b0; md_lo_we = 1'b0;
        check("mt_both hi", md_hi, 32'hAAAA);
        check("mt_both lo", md_lo, 32'hAAAA);

        // Abort in CALC cycle 10.
        md_start = 1'b1; md_op = OP_MULTU; md_a = 32'd5; md_b = 32'd6;
        @(negedge clk);
        md_start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst busy", {31'd0, md_busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", {31'd0, md_busy}, 32'd0);
        check("abort done", {31'd0, md_done}, 32'd0);
        check("abort hi", md_hi, 32'd0);
        check("abort lo", md_lo, 32'd0);
        rst = 1'b0;
        v_tmp = '{OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0};
        run_op(v_tmp, "post_rst");

        @(negedge clk);
        check("idle after done", {31'd0, md_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
